// File: rtl/axis_pkt_stats.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pkt_stats
//  Description : Passive AXI4-Stream tap. Measures the byte length of each
//                packet from tkeep, flags malformed/oversize packets and keeps
//                saturating packet/byte/error counters plus min/max length of
//                good packets. Never drives tready.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_stats #(
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int LEN_WIDTH     = 16,
  parameter int CNT_WIDTH     = 32,
  parameter int MAX_PKT_BYTES = 9600
) (
  input  logic                  axis_aclk,
  input  logic                  axis_aresetn,
  input  logic                  axis_tvalid,
  input  logic                  axis_tready,
  input  logic [DATA_WIDTH-1:0] axis_tdata,
  input  logic                  axis_tlast,
  input  logic [KEEP_WIDTH-1:0] axis_tkeep,
  input  logic                  stat_clear,
  output logic                  pkt_len_valid,
  output logic [LEN_WIDTH-1:0]  pkt_len_bytes,
  output logic                  pkt_err,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  byte_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [LEN_WIDTH-1:0]  max_len,
  output logic [LEN_WIDTH-1:0]  min_len
);

  // Accumulator carries one extra bit so "at or beyond 2^LEN_WIDTH" is
  // representable; it sticks at 2^LEN_WIDTH instead of wrapping.
  localparam int C_ACC_W = LEN_WIDTH + 1;
  localparam int C_SUM_W = LEN_WIDTH + 2;
  localparam int C_KC_W  = $clog2(KEEP_WIDTH + 1);
  localparam logic [C_ACC_W-1:0] C_ACC_SAT = {1'b1, {LEN_WIDTH{1'b0}}};

  // tdata is carried only for tap compatibility.
  logic unused_tdata;
  assign unused_tdata = ^axis_tdata;

  logic [C_ACC_W-1:0]   acc_q, acc_d;
  logic                 err_q, err_d;
  logic                 len_valid_q, len_valid_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 perr_q, perr_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [LEN_WIDTH-1:0] max_len_q, max_len_d;
  logic [LEN_WIDTH-1:0] min_len_q, min_len_d;

  logic                 beat;
  logic                 done;
  logic [C_KC_W-1:0]    keep_ones;
  logic                 keep_full;
  logic                 keep_contig;
  logic                 beat_legal;
  logic [C_KC_W-1:0]    beat_bytes;
  logic [C_SUM_W-1:0]   acc_sum;
  logic [C_ACC_W-1:0]   acc_next;
  logic [LEN_WIDTH-1:0] len_final;
  logic                 oversize;
  logic                 err_final;

  // Beat qualification, tkeep legality and the length of the packet so far.
  always_comb begin
    keep_ones = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_ones = keep_ones + C_KC_W'(axis_tkeep[i]);
    end
    beat        = axis_tvalid & axis_tready;
    done        = beat & axis_tlast;
    keep_full   = &axis_tkeep;
    // Contiguous from LSB: non-zero and x & (x+1) == 0.
    keep_contig = (axis_tkeep != '0) &&
                  ((axis_tkeep & (axis_tkeep + KEEP_WIDTH'(1))) == '0);
    beat_legal  = axis_tlast ? keep_contig : keep_full;
    beat_bytes  = beat_legal ? keep_ones : '0;
    acc_sum     = C_SUM_W'(acc_q) + C_SUM_W'(beat_bytes);
    acc_next    = (acc_sum >= C_SUM_W'(C_ACC_SAT)) ? C_ACC_SAT : acc_sum[C_ACC_W-1:0];
    len_final   = acc_next[LEN_WIDTH] ? '1 : acc_next[LEN_WIDTH-1:0];
    oversize    = 64'(acc_next) > 64'(MAX_PKT_BYTES);
    err_final   = err_q | ~beat_legal | oversize;
  end

  // Next state of the in-flight accumulator and the per-packet result.
  always_comb begin
    acc_d       = acc_q;
    err_d       = err_q;
    len_valid_d = done;
    len_d       = len_q;
    perr_d      = perr_q;
    if (beat) begin
      if (axis_tlast) begin
        acc_d  = '0;
        err_d  = 1'b0;
        len_d  = len_final;
        perr_d = err_final;
      end else begin
        acc_d  = acc_next;
        err_d  = err_q | ~beat_legal;
      end
    end
  end

  // Statistics: clear applies first, then the completing packet is folded in.
  always_comb begin
    logic [CNT_WIDTH:0] byte_sum;
    pkt_cnt_d  = stat_clear ? '0 : pkt_cnt_q;
    byte_cnt_d = stat_clear ? '0 : byte_cnt_q;
    err_cnt_d  = stat_clear ? '0 : err_cnt_q;
    max_len_d  = stat_clear ? '0 : max_len_q;
    min_len_d  = stat_clear ? '1 : min_len_q;
    byte_sum   = (CNT_WIDTH + 1)'(byte_cnt_d) + (CNT_WIDTH + 1)'(len_final);
    if (done) begin
      if (pkt_cnt_d != '1) begin
        pkt_cnt_d = pkt_cnt_d + CNT_WIDTH'(1);
      end
      byte_cnt_d = byte_sum[CNT_WIDTH] ? '1 : byte_sum[CNT_WIDTH-1:0];
      if (err_final) begin
        if (err_cnt_d != '1) begin
          err_cnt_d = err_cnt_d + CNT_WIDTH'(1);
        end
      end else begin
        if (len_final > max_len_d) max_len_d = len_final;
        if (len_final < min_len_d) min_len_d = len_final;
      end
    end
  end

  // Packet accumulator and per-packet result registers.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      acc_q       <= '0;
      err_q       <= 1'b0;
      len_valid_q <= 1'b0;
      len_q       <= '0;
      perr_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      err_q       <= err_d;
      len_valid_q <= len_valid_d;
      len_q       <= len_d;
      perr_q      <= perr_d;
    end
  end

  // Statistics registers; min_len idles at all-ones so the first good packet wins.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
      max_len_q  <= '0;
      min_len_q  <= '1;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
      max_len_q  <= max_len_d;
      min_len_q  <= min_len_d;
    end
  end

  assign pkt_len_valid = len_valid_q;
  assign pkt_len_bytes = len_q;
  assign pkt_err       = perr_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign byte_cnt      = byte_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign max_len       = max_len_q;
  assign min_len       = min_len_q;

endmodule
`default_nettype wire
